// File: rtl/ram_pkg.sv
// ram_pkg: shared op type, default sizing, width helper and even-parity helper for ram_mc
package ram_pkg;
   typedef enum logic {READ = 1'b0, WRITE = 1'b1} op_t;
   localparam int WORD_SIZE   = 20;
   localparam int WORD_AMOUNT = 30;
   localparam int CHANNELS    = 2;
   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   localparam int ADDR_W = addr_w(WORD_AMOUNT);
   function automatic logic even_parity(input logic [63:0] d);
      return ^d;
   endfunction
endpackage

// File: rtl/ram_mc_rr_arbiter.sv
// rr_arbiter: round-robin one-hot arbiter that owns the rotating priority pointer
// Ports: clk, rst (sync, active-high); req = requests; upd = advance pointer past this cycle's winner;
// grant = one-hot combinational grant.
import ram_pkg::*;
module rr_arbiter #(
   parameter int channels = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [channels-1:0] req,
   input  logic                upd,
   output logic [channels-1:0] grant
);
   localparam int pw = addr_w(channels);
   logic [pw-1:0] r_ptr;
   logic [pw-1:0] w_nxt;
   int w_d;
   int w_best;
   // winner is the requester with the smallest circular distance from the pointer
   always_comb begin
      grant = '0;
      w_nxt = r_ptr;
      w_d = 0;
      w_best = channels;
      for (int i = 0; i < channels; i++) begin
         w_d = (i + channels - int'(r_ptr)) % channels;
         if (req[i] && w_d < w_best) begin
            w_best = w_d;
            grant = '0;
            grant[i] = 1'b1;
            w_nxt = pw'((i + 1) % channels);
         end
      end
   end
   always_ff @(posedge clk)
      if (rst) r_ptr <= '0;
      else if (upd) r_ptr <= w_nxt;
endmodule

// File: rtl/ram_mc.sv
// ram_mc: multi-channel single-port word RAM shared by round-robin arbitration
// Ports: clk, rst (sync, active-high); per channel select/operation/address/wdata in;
// grant (combinational one-hot), rvalid (1-cycle), rdata (registered, held), addr_err (1-cycle) out.
// Optional: define RAM_PARITY_EN to store an even-parity bit per word and add the perr output.
import ram_pkg::*;
module ram_mc #(
   parameter  int word_size   = WORD_SIZE,
   parameter  int word_amount = WORD_AMOUNT,
   parameter  int channels    = CHANNELS,
   localparam int aw          = addr_w(word_amount)
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [channels-1:0]                select,
   input  logic [channels-1:0]                operation,
   input  logic [channels-1:0][aw-1:0]        address,
   input  logic [channels-1:0][word_size-1:0] wdata,
   output logic [channels-1:0]                grant,
   output logic [channels-1:0]                rvalid,
   output logic [channels-1:0][word_size-1:0] rdata,
   output logic [channels-1:0]                addr_err
`ifdef RAM_PARITY_EN
   ,output logic [channels-1:0]               perr
`endif
);
`ifdef RAM_PARITY_EN
   localparam int mw = word_size + 1;
`else
   localparam int mw = word_size;
`endif
   logic [mw-1:0]        r_mem [word_amount];
   logic [channels-1:0]  r_rvalid;
   logic [aw-1:0]        w_addr;
   logic [word_size-1:0] w_wdata;
   logic [mw-1:0]        w_wword;
   logic [mw-1:0]        w_rword;
   op_t                  w_op;
   logic                 w_any;
   logic                 w_inr;
   logic                 w_rd;
   // requests are masked during reset so nothing is granted or written in a reset cycle
   rr_arbiter #(.channels(channels)) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (select & ~{channels{rst}}),
      .upd   (w_any),
      .grant (grant)
   );
   always_comb begin
      w_addr = '0;
      w_wdata = '0;
      w_op = READ;
      for (int i = 0; i < channels; i++)
         if (grant[i]) begin
            w_addr = address[i];
            w_wdata = wdata[i];
            w_op = op_t'(operation[i]);
         end
   end
   assign w_any   = |grant;
   assign w_inr   = int'(w_addr) < word_amount;
   assign w_rd    = w_any && w_op == READ;
   assign w_rword = w_inr ? r_mem[w_addr] : '0;
`ifdef RAM_PARITY_EN
   assign w_wword = {even_parity(64'(w_wdata)), w_wdata};
`else
   assign w_wword = w_wdata;
`endif
   always_ff @(posedge clk)
      if (w_any && w_op == WRITE && w_inr) r_mem[w_addr] <= w_wword;
   always_ff @(posedge clk)
      if (rst) begin
         r_rvalid <= '0;
         addr_err <= '0;
         rdata <= '0;
      end else begin
         r_rvalid <= grant & {channels{w_rd}};
         addr_err <= grant & {channels{!w_inr}};
         for (int i = 0; i < channels; i++)
            if (grant[i] && w_rd) rdata[i] <= w_rword[word_size-1:0];
      end
   // a reset arriving while a read result is pending kills the pulse
   assign rvalid = r_rvalid & ~{channels{rst}};
`ifdef RAM_PARITY_EN
   logic [channels-1:0] r_perr;
   always_ff @(posedge clk)
      if (rst) r_perr <= '0;
      else r_perr <= grant & {channels{w_rd && w_inr &&
                     (even_parity(64'(w_rword[word_size-1:0])) != w_rword[word_size])}};
   assign perr = r_perr & ~{channels{rst}};
`endif
endmodule
